ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 177 +++++++++++++++++
 tb/tb_ex_mem_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Two-slot elastic buffer between EX and MEM. The main slot drives mem_*,
//   and the skid slot absorbs one extra entry while MEM stalls. On each
//   accepted entry the stage also updates the stored flags, raises a
//   one-cycle branch redirect and, when built with EX_MEM_ERROR_TRAP_EN,
//   sets a sticky error trap.
//
// Optional feature macro: EX_MEM_ERROR_TRAP_EN
//   defined   -> error_trap is a sticky register, cleared only by rst_n
//   undefined -> error_trap is tied to 0
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   ex_valid / ex_ready   EX-side handshake
//   ex_alu_op, ex_result, ex_zero, ex_flags, ex_mask, ex_ctrl, ex_store
//                         EX entry fields
//   flush                 drop buffered and incoming entries
//   mem_valid / mem_ready MEM-side handshake
//   mem_result, mem_zero, mem_ctrl, mem_store
//                         head entry fields
//   flags_q               stored flags {error, equal, below, above, overflow}
//   branch_taken          one-cycle redirect pulse
//   branch_target         redirect address
//   error_trap            sticky error indication
//
// state | meaning
// EMPTY | no entry buffered
// ONE   | main slot holds the head entry
// TWO   | main and skid both hold entries, EX is stalled

module ex_mem_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_alu_op,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_zero,
    input  logic [4:0]        ex_flags,
    input  logic [4:0]        ex_mask,
    input  logic [7:0]        ex_ctrl,
    input  logic [DATA_W-1:0] ex_store,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic              mem_zero,
    output logic [7:0]        mem_ctrl,
    output logic [DATA_W-1:0] mem_store,
    output logic [4:0]        flags_q,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              error_trap
);

    localparam logic [4:0] OP_ADD  = 5'b00110;
    localparam logic [4:0] OP_SUB  = 5'b00111;
    localparam logic [4:0] OP_MUL  = 5'b01000;
    localparam logic [4:0] OP_DIV  = 5'b01001;
    localparam logic [4:0] OP_CMP  = 5'b01110;
    localparam logic [4:0] OP_JR   = 5'b10000;
    localparam logic [4:0] OP_JPC  = 5'b10001;
    localparam logic [4:0] OP_BRFL = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [7:0]        ctrl;
        logic [DATA_W-1:0] store;
    } entry_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   accept;
    logic   drain;
    logic   flag_op;
    logic   branch_hit;

    assign ex_ready  = (state != TWO);
    assign mem_valid = (state != EMPTY);
    assign accept    = ex_valid & ex_ready & ~flush;
    assign drain     = mem_valid & mem_ready;

    assign in_entry = '{result: ex_result, zero: ex_zero, ctrl: ex_ctrl, store: ex_store};

    assign mem_result = main_q.result;
    assign mem_zero   = main_q.zero;
    assign mem_ctrl   = main_q.ctrl;
    assign mem_store  = main_q.store;

    always_comb begin
        flag_op = (ex_alu_op == OP_ADD) || (ex_alu_op == OP_SUB) ||
                  (ex_alu_op == OP_MUL) || (ex_alu_op == OP_DIV) ||
                  (ex_alu_op == OP_CMP);
        // BRFL compares against flags_q before this entry could update it;
        // BRFL itself is not flag-setting so no bypass is needed.
        branch_hit = (ex_alu_op == OP_JR) || (ex_alu_op == OP_JPC) ||
                     (ex_alu_op == OP_CALL) ||
                     ((ex_alu_op == OP_BRFL) && (flags_q == ex_mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        skid_q <= in_entry;
                        state  <= TWO;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q       <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            branch_taken <= accept & branch_hit;
            if (accept && branch_hit) begin
                branch_target <= ex_result;
            end
            if (accept && flag_op) begin
                flags_q <= ex_flags;
            end
        end
    end

`ifdef EX_MEM_ERROR_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_trap <= 1'b0;
        end else if (accept && flag_op && ex_flags[4]) begin
            error_trap <= 1'b1;
        end
    end
`else
    assign error_trap = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_alu_op;
    logic [31:0] ex_result;
    logic        ex_zero;
    logic [4:0]  ex_flags;
    logic [4:0]  ex_mask;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_store;
    logic        flush;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_result;
    logic        mem_zero;
    logic [7:0]  mem_ctrl;
    logic [31:0] mem_store;
    logic [4:0]  flags_q;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        error_trap;

    int checks = 0;
    int errors = 0;

`ifdef EX_MEM_ERROR_TRAP_EN
    localparam logic TRAP_EXP = 1'b1;
`else
    localparam logic TRAP_EXP = 1'b0;
`endif

    ex_mem_stage #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_op     (ex_alu_op),
        .ex_result     (ex_result),
        .ex_zero       (ex_zero),
        .ex_flags      (ex_flags),
        .ex_mask       (ex_mask),
        .ex_ctrl       (ex_ctrl),
        .ex_store      (ex_store),
        .flush         (flush),
        .mem_ready     (mem_ready),
        .mem_valid     (mem_valid),
        .mem_result    (mem_result),
        .mem_zero      (mem_zero),
        .mem_ctrl      (mem_ctrl),
        .mem_store     (mem_store),
        .flags_q       (flags_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .error_trap    (error_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] res,
                         input logic [4:0] fl, input logic [4:0] mk);
        ex_valid  = v;
        ex_alu_op = op;
        ex_result = res;
        ex_flags  = fl;
        ex_mask   = mk;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_alu_op = '0; ex_result = '0; ex_zero = 1'b0;
        ex_flags = '0; ex_mask = '0; ex_ctrl = '0; ex_store = '0; flush = 1'b0; mem_ready = 1'b0;
        #2;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_result", mem_result, 0);
        chk("rst_mem_ctrl", mem_ctrl, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_branch_taken", branch_taken, 0);
        chk("rst_branch_target", branch_target, 0);
        chk("rst_error_trap", error_trap, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single ADD entry, flags captured, fields passed through
        mem_ready = 1'b1;
        ex_ctrl = 8'hA5; ex_store = 32'hDEAD_BEEF; ex_zero = 1'b1;
        drive(1, 5'b00110, 32'h5, 5'b00001, 5'b0);
        step();
        chk("add_mem_valid", mem_valid, 1);
        chk("add_mem_result", mem_result, 32'h5);
        chk("add_mem_ctrl", mem_ctrl, 32'hA5);
        chk("add_mem_store", mem_store, 32'hDEAD_BEEF);
        chk("add_mem_zero", mem_zero, 1);
        chk("add_flags_q", flags_q, 5'b00001);
        chk("add_no_branch", branch_taken, 0);
        ex_zero = 1'b0;
        drive(0, 5'b00000, 0, 0, 0);
        step();
        chk("drain_mem_valid", mem_valid, 0);
        chk("drain_ex_ready", ex_ready, 1);

        // backpressure: 1,2,3 with non-flag op carrying junk flags
        mem_ready = 1'b0;
        drive(1, 5'b00000, 32'h1, 5'b11111, 0);
        step();
        chk("bp1_ex_ready", ex_ready, 1);
        chk("bp1_mem_result", mem_result, 32'h1);
        drive(1, 5'b00000, 32'h2, 5'b11111, 0);
        step();
        chk("bp2_ex_ready", ex_ready, 0);
        chk("bp2_mem_result", mem_result, 32'h1);
        drive(1, 5'b00000, 32'h3, 5'b11111, 0);
        step();
        chk("bp3_hold_ex_ready", ex_ready, 0);
        chk("bp3_hold_mem_result", mem_result, 32'h1);
        mem_ready = 1'b1;
        step();
        chk("rel1_mem_result", mem_result, 32'h2);
        chk("rel1_ex_ready", ex_ready, 1);
        step();
        chk("rel2_mem_result", mem_result, 32'h3);
        chk("rel2_mem_valid", mem_valid, 1);
        drive(0, 5'b00000, 0, 0, 0);
        step();
        chk("rel3_mem_valid", mem_valid, 0);
        chk("nonflag_flags_q", flags_q, 5'b00001);

        // CMP then BRFL hit / miss, then JR
        drive(1, 5'b01110, 32'h0, 5'b01000, 0);
        step();
        chk("cmp_flags_q", flags_q, 5'b01000);
        chk("cmp_no_branch", branch_taken, 0);
        drive(1, 5'b10010, 32'h100, 5'b00000, 5'b01000);
        step();
        chk("brfl_hit_taken", branch_taken, 1);
        chk("brfl_hit_target", branch_target, 32'h100);
        chk("brfl_enters_buffer", mem_result, 32'h100);
        drive(0, 5'b00000, 0, 0, 0);
        step();
        chk("brfl_pulse_end", branch_taken, 0);
        chk("brfl_target_hold", branch_target, 32'h100);
        drive(1, 5'b10010, 32'h200, 5'b00000, 5'b00010);
        step();
        chk("brfl_miss_taken", branch_taken, 0);
        chk("brfl_miss_target", branch_target, 32'h100);
        drive(1, 5'b10000, 32'h300, 5'b00000, 0);
        step();
        chk("jr_taken", branch_taken, 1);
        chk("jr_target", branch_target, 32'h300);
        drive(0, 5'b00000, 0, 0, 0);
        step();

        // flush in TWO with ex_valid and mem_ready
        mem_ready = 1'b0;
        drive(1, 5'b00000, 32'hA, 0, 0);
        step();
        drive(1, 5'b00000, 32'hB, 0, 0);
        step();
        chk("two_ex_ready", ex_ready, 0);
        flush = 1'b1; mem_ready = 1'b1;
        drive(1, 5'b01110, 32'h0, 5'b00100, 0);
        step();
        chk("flush2_mem_valid", mem_valid, 0);
        chk("flush2_ex_ready", ex_ready, 1);
        chk("flush2_flags_q", flags_q, 5'b01000);
        chk("flush2_branch", branch_taken, 0);
        // flush with a branch arriving while ready
        flush = 1'b0; mem_ready = 1'b0;
        drive(1, 5'b00000, 32'hC, 0, 0);
        step();
        flush = 1'b1;
        drive(1, 5'b10000, 32'h400, 0, 0);
        step();
        chk("flush1_mem_valid", mem_valid, 0);
        chk("flush1_branch", branch_taken, 0);
        chk("flush1_target", branch_target, 32'h300);
        drive(1, 5'b01110, 32'h0, 5'b00100, 0);
        step();
        chk("flush0_flags_q", flags_q, 5'b01000);
        flush = 1'b0; mem_ready = 1'b1;
        drive(1, 5'b00000, 32'hD, 0, 0);
        step();
        chk("post_flush_result", mem_result, 32'hD);
        drive(0, 5'b00000, 0, 0, 0);
        step();

        // DIV with error flag
        drive(1, 5'b01001, 32'h0, 5'b10000, 0);
        step();
        chk("div_flags_q", flags_q, 5'b10000);
        chk("div_error_trap", error_trap, TRAP_EXP);
        drive(0, 5'b00000, 0, 0, 0);
        flush = 1'b1;
        step();
        chk("trap_after_flush", error_trap, TRAP_EXP);
        flush = 1'b0;
        step();
        chk("trap_sticky", error_trap, TRAP_EXP);

        // async reset mid-operation
        mem_ready = 1'b0;
        drive(1, 5'b00000, 32'hE, 0, 0);
        step();
        drive(1, 5'b00000, 32'hF, 0, 0);
        step();
        drive(0, 5'b00000, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_valid", mem_valid, 0);
        chk("arst_ex_ready", ex_ready, 1);
        chk("arst_mem_result", mem_result, 0);
        chk("arst_flags_q", flags_q, 0);
        chk("arst_error_trap", error_trap, 0);
        chk("arst_target", branch_target, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_mem_valid", mem_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
